// File: rtl/pt_write_buffer_if.sv
// pt_write_buffer_if
//   Bundles the two handshakes around pt_write_buffer.
//   Pixel-write side: pt_pixel_write[17:0], pt_x[9:0], pt_y[8:0] and pt_wr come from
//   projective_transform. ptflag goes back to it as the "may write next cycle" permit.
//   Memory side: mem_wr_req, mem_addr[18:0] and mem_data[17:0] show the FIFO head.
//   mem_wr_ack comes back from memory_interface.
//   modport slave  : the write buffer's view.
//   modport master : the surrounding environment's view (transform + memory).
interface pt_write_buffer_if;
  logic [17:0] pt_pixel_write;
  logic [9:0]  pt_x;
  logic [8:0]  pt_y;
  logic        pt_wr;
  logic        ptflag;
  logic        mem_wr_req;
  logic [18:0] mem_addr;
  logic [17:0] mem_data;
  logic        mem_wr_ack;

  modport slave (
    input  pt_pixel_write, pt_x, pt_y, pt_wr, mem_wr_ack,
    output ptflag, mem_wr_req, mem_addr, mem_data
  );

  modport master (
    output pt_pixel_write, pt_x, pt_y, pt_wr, mem_wr_ack,
    input  ptflag, mem_wr_req, mem_addr, mem_data
  );
endinterface

// File: rtl/pt_write_buffer.sv
// pt_write_buffer
//   Accepts transformed pixel writes and discards off-screen coordinates. Each
//   on-screen write has its (x,y) converted to a linear frame-buffer address
//   (y*640 + x). The address and pixel are queued in a small show-ahead FIFO,
//   and the FIFO is drained to memory with a req/ack handshake.
// Ports
//   clk           : system clock
//   reset         : synchronous, active-high; clears pointers, flags and storage
//   bus (slave)   : pixel-write inputs, ptflag permit, memory req/addr/data/ack
//   overflow      : sticky; an on-screen write arrived while the FIFO was full
//   dropped_count : 16-bit saturating count of off-screen writes (DROP_COUNT_EN only)
// Configuration
//   Define DROP_COUNT_EN to add the dropped_count port and its counter.
module pt_write_buffer #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480
) (
  input  logic                clk,
  input  logic                reset,
  pt_write_buffer_if.slave    bus,
  output logic                overflow
`ifdef DROP_COUNT_EN
  ,
  output logic [15:0]         dropped_count
`endif
);

  localparam int CNT_W = LOG_DEPTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  // Two free slots are kept when ptflag is high. This absorbs the one write that
  // can already be in flight when ptflag falls.
  localparam logic [CNT_W-1:0] FLAG_MAX = CNT_W'(DEPTH - 2);
  localparam logic [9:0]       X_LIM    = 10'(H_ACTIVE);
  localparam logic [8:0]       Y_LIM    = 9'(V_ACTIVE);

  logic [18:0]          addr_q [DEPTH];
  logic [18:0]          addr_d [DEPTH];
  logic [17:0]          data_q [DEPTH];
  logic [17:0]          data_d [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ptflag_q, ptflag_d;
  logic                 overflow_q, overflow_d;

  logic        on_screen;
  logic        pop;
  logic        push;
  logic        lost;
  logic [18:0] y_ext;
  logic [18:0] push_addr;

  assign on_screen = (bus.pt_x < X_LIM) && (bus.pt_y < Y_LIM);
  // y*640 written as y*512 + y*128. The largest result is 307199, which fits in 19 bits.
  assign y_ext     = {10'd0, bus.pt_y};
  assign push_addr = (y_ext << 9) + (y_ext << 7) + {9'd0, bus.pt_x};
  assign pop       = (count_q != '0) && bus.mem_wr_ack;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = bus.pt_wr && on_screen && ((count_q != FULL_CNT) || pop);
  assign lost      = bus.pt_wr && on_screen && (count_q == FULL_CNT) && !pop;

  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | lost;
    if (push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = bus.pt_pixel_write;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ptflag_d = (count_d <= FLAG_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '{default: '0};
      data_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ptflag_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ptflag_q   <= ptflag_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.pt_wr && !on_screen && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dropped_count = drop_cnt_q;
`endif

  // Show-ahead: the head entry is read straight from storage.
  assign bus.mem_wr_req = (count_q != '0);
  assign bus.mem_addr   = addr_q[rd_ptr_q];
  assign bus.mem_data   = data_q[rd_ptr_q];
  assign bus.ptflag     = ptflag_q;
  assign overflow       = overflow_q;

endmodule
